// File: rtl/dmem_responder.sv
// Word-addressed data memory with combinational reads and a read-old-on-write port.
// Optional MMIO region (cycle counter, TOHOST/halt) enabled by defining DMEM_MMIO_EN.
module dmem_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hFFFF
) (
  input  logic        i_Clk_1,
  input  logic        i_Rstn_1,
  input  logic [31:0] i_MemoryStoreAddr_32,
  input  logic [31:0] i_MemoryStoreData_32,
  input  logic        i_MemoryWriteEnable_1,
  output logic [31:0] o_MemoryLoadData_32,
  output logic        o_Halt_1,
  output logic [31:0] o_ToHost_32
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       ram_q [DEPTH];
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       ram_rdata;
  logic              ram_we;

  // Upper address bits alias and byte-lane bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{i_MemoryStoreAddr_32[31:ADDR_W+2], i_MemoryStoreAddr_32[1:0], i_Rstn_1};

  assign ram_idx   = i_MemoryStoreAddr_32[ADDR_W+1:2];
  assign ram_rdata = ram_q[ram_idx];

`ifdef DMEM_MMIO_EN
  logic        mmio_sel;
  logic [15:0] mmio_off;
  logic [31:0] mmio_rdata;
  logic [63:0] mtime_q, mtime_d;
  logic        halt_q, halt_d;
  logic [31:0] tohost_q, tohost_d;

  always_comb begin
    mmio_sel   = (i_MemoryStoreAddr_32[31:16] == MMIO_BASE);
    mmio_off   = i_MemoryStoreAddr_32[15:0];
    mmio_rdata = 32'd0;
    case (mmio_off)
      16'h0000: mmio_rdata = mtime_q[31:0];
      16'h0004: mmio_rdata = mtime_q[63:32];
      16'h0008: mmio_rdata = tohost_q;
      default:  mmio_rdata = 32'd0;
    endcase

    // The counter also advances on the halting edge; it freezes from then on.
    mtime_d  = halt_q ? mtime_q : mtime_q + 64'd1;
    halt_d   = halt_q;
    tohost_d = tohost_q;
    if (i_MemoryWriteEnable_1 && !halt_q && mmio_sel && (mmio_off == 16'h0008) &&
        (i_MemoryStoreData_32 != 32'd0)) begin
      halt_d   = 1'b1;
      tohost_d = i_MemoryStoreData_32;
    end

    ram_we              = i_MemoryWriteEnable_1 && !halt_q && !mmio_sel;
    o_MemoryLoadData_32 = mmio_sel ? mmio_rdata : ram_rdata;
  end

  always_ff @(posedge i_Clk_1 or negedge i_Rstn_1) begin
    if (!i_Rstn_1) begin
      mtime_q  <= 64'd0;
      halt_q   <= 1'b0;
      tohost_q <= 32'd0;
    end else begin
      mtime_q  <= mtime_d;
      halt_q   <= halt_d;
      tohost_q <= tohost_d;
    end
  end

  assign o_Halt_1    = halt_q;
  assign o_ToHost_32 = tohost_q;
`else
  always_comb begin
    ram_we              = i_MemoryWriteEnable_1;
    o_MemoryLoadData_32 = ram_rdata;
  end

  assign o_Halt_1    = 1'b0;
  assign o_ToHost_32 = 32'd0;
`endif

  // RAM is deliberately not reset; reads in the write cycle see the old word.
  always_ff @(posedge i_Clk_1) begin
    if (ram_we) begin
      ram_q[ram_idx] <= i_MemoryStoreData_32;
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the core's memory-stage port. Accepts the word-aligned address, merged store word and write enable produced by the memory stage, and returns the addressed word combinationally as load data. Load data must be valid in the same cycle, because sub-word stores are merged from it. Holds a word-addressed RAM plus a small memory-mapped region: a free-running cycle counter and a halt/"tohost" register used by the test harness.

## Interface
Parameters:
- ADDR_W, 12: RAM index width; RAM holds 2^ADDR_W 32-bit words (16 KiB default).
- MMIO_BASE, 16'hFFFF: value of address bits [31:16] that selects the MMIO region.

Ports (one clock; reset is asynchronous and active-low):
- i_Clk_1  input  1  clock; all state updates on rising edge.
- i_Rstn_1  input  1  asynchronous active-low reset.
- i_MemoryStoreAddr_32  input  32  word-aligned byte address (bits [1:0] = 0) for both load and store.
- i_MemoryStoreData_32  input  32  full word to write; already lane-merged by the memory stage.
- i_MemoryWriteEnable_1  input  1  write the word at the next rising edge.
- o_MemoryLoadData_32  output  32  word at i_MemoryStoreAddr_32; combinational.
- o_Halt_1  output  1  sticky; set by a nonzero write to TOHOST.
- o_ToHost_32  output  32  value latched by the halting TOHOST write.

## Operation
- Decode: MMIO when `DMEM_MMIO_EN` is defined and i_MemoryStoreAddr_32[31:16] == MMIO_BASE; otherwise RAM.
- RAM index = i_MemoryStoreAddr_32[ADDR_W+1:2]; remaining upper bits ignored, so addresses alias. Bits [1:0] ignored.
- RAM read: combinational from the array. RAM write: on rising edge when i_MemoryWriteEnable_1 && !o_Halt_1 && RAM selected.
- MMIO offsets (address bits [15:0]):
  - 0x0000: MTIME_LO. Read-only, counter[31:0].
  - 0x0004: MTIME_HI. Read-only, counter[63:32].
  - 0x0008: TOHOST. Reads return o_ToHost_32.
  - All other offsets read 0. Writes to them and to MTIME are ignored.
- Counter: 64-bit. Increments by 1 every cycle while o_Halt_1 = 0 and freezes once halted. Wraps from 2^64-1 to 0.
- TOHOST write with nonzero data while not halted: o_ToHost_32 <= data and o_Halt_1 <= 1 at the same edge. A zero-valued write has no effect.
- Once halted, every write (RAM and MMIO) is ignored until reset. Reads still work.

## Timing
- Reset: o_Halt_1 = 0, o_ToHost_32 = 0, counter = 0. RAM contents are not reset (X until written).
- Load latency 0: o_MemoryLoadData_32 follows the address within the same cycle.
- Store latency 1: new data is visible to reads from the cycle after the write edge.
- Read-during-write to the same address: the read returns the OLD word. The memory stage's read-modify-write depends on this.
- Counter read in cycle N returns N cycles since reset deassertion, with the first post-reset cycle reading 0.
- Reset asserted mid-run clears the counter, halt and tohost immediately (asynchronously). RAM is unchanged.

## Configuration
- `DMEM_MMIO_EN` defined: MMIO decode, counter, TOHOST and halt logic are present as described above.
- `DMEM_MMIO_EN` undefined: every address maps to RAM (MMIO_BASE addresses alias into RAM). o_Halt_1 and o_ToHost_32 are tied to 0, and no counter exists.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, then read 0x10 on the next cycle -> 0xDEADBEEF. In the write cycle itself, a read of 0x10 returns the prior contents.
- Write 0x11223344 to 0x10, then 0x55667788 to 0x10 + 4·2^ADDR_W -> read 0x10 returns 0x55667788 (alias).
- With MMIO: read 0xFFFF_0000 at the 5th cycle after reset release -> 4. Write 0x1234 to 0xFFFF_0000 -> the count is unaffected.
- With MMIO: write 0 to 0xFFFF_0008 -> o_Halt_1 stays 0. Then write 0x1 -> o_Halt_1 = 1 and o_ToHost_32 = 1 next cycle, and the counter freezes. A subsequent RAM write to 0x20 leaves 0x20 unchanged.
- Assert i_Rstn_1 low mid-cycle while halted -> o_Halt_1 and o_ToHost_32 go to 0 without a clock edge. After release, the counter restarts from 0.
- Without the macro: write 0xCAFEF00D to 0xFFFF_0008 -> read 0x0000_0008 returns 0xCAFEF00D, and o_Halt_1 stays 0.
